vc_output_arbiter: RTL and testbench

- Sits directly downstream of the input module's four VC buffers (N, S, E, W).
- Picks a non-empty VC round-robin and issues a one-hot read enable plus the encoded rr_select back to the buffers.
- Captures the returned flit into a 2-entry output queue and presents it on a valid/ready link toward the crossbar/output port.
- Provides the read-side control that the input module's rr_select/read_en inputs need.

---
 rtl/vc_output_arbiter_if.sv | 29 ++
 rtl/vc_output_arbiter.sv | 151 +++++++++++++++
 tb/tb_vc_output_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_output_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vc_output_arbiter_if
// Purpose  : Buffer read-side and crossbar-side link of the VC output arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface vc_output_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [3:0]          vc_empty;
  logic [4*DATA_W-1:0] vc_data;
  logic [3:0]          rd_en;
  logic [1:0]          rr_select;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic [1:0]          out_vc;

  // master = the arbiter; slave = the buffers plus the downstream port
  modport master (
    input  vc_empty, vc_data, out_ready,
    output rd_en, rr_select, out_data, out_valid, out_vc
  );
  modport slave (
    output vc_empty, vc_data, out_ready,
    input  rd_en, rr_select, out_data, out_valid, out_vc
  );
endinterface
`default_nettype wire

// File: rtl/vc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vc_output_arbiter
// Purpose  : Round-robin reader of four VC buffers feeding a 2-entry output
//            queue. Define VC_PKT_LOCK_EN for wormhole packet locking.
// Revision : 1.0 - initial release
// ============================================================================
module vc_output_arbiter #(
  parameter int DATA_W   = 8,
  parameter int TAIL_BIT = 7
) (
  input wire                  clk,
  input wire                  reset,
  vc_output_arbiter_if.master bus
);

  if (TAIL_BIT < 0 || TAIL_BIT >= DATA_W) begin : g_tail_check
    $error("vc_output_arbiter: TAIL_BIT outside the flit");
  end

`ifdef VC_PKT_LOCK_EN
  typedef enum logic [0:0] {LK_FREE = 1'b0, LK_LOCKED = 1'b1} lock_state_t;
  lock_state_t r_lock_state;
  logic [1:0]  r_lock_vc;
`endif

  logic [1:0]        r_ptr;
  logic              r_cap_valid;
  logic [1:0]        r_cap_sel;
  logic [DATA_W-1:0] r_q_data [2];
  logic [1:0]        r_q_vc   [2];
  logic              r_q_rd;
  logic              r_q_wr;
  logic [1:0]        r_q_cnt;

  logic [3:0]        w_elig;
  logic              w_found;
  logic [1:0]        w_gnt;
  logic              w_room;
  logic              w_issue;
  logic              w_out_valid;
  logic              w_pop;
  logic [1:0]        w_occ;
  logic [DATA_W-1:0] w_cap_flit;

  assign w_out_valid = (r_q_cnt != 2'd0);
  assign w_pop       = w_out_valid && bus.out_ready;
  // queued plus in-flight never exceeds 2, so the 2-bit sum cannot wrap
  assign w_occ       = r_q_cnt + {1'b0, r_cap_valid};

  always_comb begin
    w_elig = ~bus.vc_empty;
    w_room = (w_occ != 2'd2) || w_pop;
`ifdef VC_PKT_LOCK_EN
    if (r_lock_state == LK_LOCKED) begin
      w_elig = ~bus.vc_empty & (4'b0001 << r_lock_vc);
    end
    // lock is only known at capture, so a head read must land before the next issue
    if (r_lock_state == LK_FREE && r_cap_valid) begin
      w_room = 1'b0;
    end
`endif
  end

  always_comb begin
    w_found = 1'b0;
    w_gnt   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && w_elig[r_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_gnt   = r_ptr + 2'(k);
      end
    end
  end

  assign w_issue = w_found && w_room;

  // reset gates only the outputs; the flops are held by the async clear anyway
  assign bus.rd_en     = (w_issue && reset) ? (4'b0001 << w_gnt) : 4'b0000;
  assign bus.rr_select = (w_issue && reset) ? w_gnt : 2'b00;

  always_comb begin
    case (r_cap_sel)
      2'd0:    w_cap_flit = bus.vc_data[DATA_W-1:0];
      2'd1:    w_cap_flit = bus.vc_data[2*DATA_W-1:DATA_W];
      2'd2:    w_cap_flit = bus.vc_data[3*DATA_W-1:2*DATA_W];
      default: w_cap_flit = bus.vc_data[4*DATA_W-1:3*DATA_W];
    endcase
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_q_data[r_q_rd];
  assign bus.out_vc    = r_q_vc[r_q_rd];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr       <= 2'd0;
      r_cap_valid <= 1'b0;
      r_cap_sel   <= 2'd0;
      r_q_rd      <= 1'b0;
      r_q_wr      <= 1'b0;
      r_q_cnt     <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_q_data[i] <= '0;
        r_q_vc[i]   <= 2'd0;
      end
`ifdef VC_PKT_LOCK_EN
      r_lock_state <= LK_FREE;
      r_lock_vc    <= 2'd0;
`endif
    end else begin
      r_cap_valid <= w_issue;
      if (w_issue) begin
        r_cap_sel <= w_gnt;
        r_ptr     <= w_gnt;
      end
      if (r_cap_valid) begin
        r_q_data[r_q_wr] <= w_cap_flit;
        r_q_vc[r_q_wr]   <= r_cap_sel;
        r_q_wr           <= ~r_q_wr;
      end
      if (w_pop) begin
        r_q_rd <= ~r_q_rd;
      end
      case ({r_cap_valid, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + 2'd1;
        2'b01:   r_q_cnt <= r_q_cnt - 2'd1;
        default: r_q_cnt <= r_q_cnt;
      endcase
`ifdef VC_PKT_LOCK_EN
      if (r_cap_valid) begin
        case (r_lock_state)
          LK_FREE: begin
            if (!w_cap_flit[TAIL_BIT]) begin
              r_lock_state <= LK_LOCKED;
              r_lock_vc    <= r_cap_sel;
            end
          end
          LK_LOCKED: begin
            if (w_cap_flit[TAIL_BIT]) begin
              r_lock_state <= LK_FREE;
            end
          end
        endcase
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_output_arbiter
// Purpose  : Vector tables, corner sequences and a queue-based random model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_output_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vc_output_arbiter_if #(.DATA_W(8)) bus ();

  vc_output_arbiter #(.DATA_W(8), .TAIL_BIT(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         rst_first;
    logic [3:0] vc_empty;
    bit         out_ready;
    logic [3:0] exp_rd_en;
    bit         exp_ov;
    logic [7:0] exp_data;
    logic [1:0] exp_vc;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] bq [4][$];
  logic [7:0] exp_d[$];
  logic [1:0] exp_v[$];
  logic [7:0] obs_d[$];
  logic [1:0] obs_v[$];
  int         mptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic vec_t mk(bit r, logic [3:0] e, bit rdy, logic [3:0] rd,
                              bit ov, logic [7:0] d, logic [1:0] v);
    vec_t t;
    t.rst_first = r; t.vc_empty = e; t.out_ready = rdy; t.exp_rd_en = rd;
    t.exp_ov = ov; t.exp_data = d; t.exp_vc = v;
    return t;
  endfunction

  task automatic const_data();
    bus.vc_data = {8'h44, 8'h33, 8'h22, 8'h11};
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    bus.vc_empty  = 4'b0000;
    bus.out_ready = 1'b1;
    const_data();
    repeat (3) begin
      @(negedge clk);
      chk("rst_rd_en", bus.rd_en, 0);
      chk("rst_out_valid", bus.out_valid, 0);
    end
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_vc", bus.out_vc, 0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.rst_first) do_reset();
    bus.vc_empty  = v.vc_empty;
    bus.out_ready = v.out_ready;
    @(negedge clk);
    chk("vec_rd_en", bus.rd_en, v.exp_rd_en);
    chk("vec_rr_select", bus.rr_select, enc(v.exp_rd_en));
    chk("vec_out_valid", bus.out_valid, v.exp_ov);
    if (v.exp_ov) begin
      chk("vec_out_data", bus.out_data, v.exp_data);
      chk("vec_out_vc", bus.out_vc, v.exp_vc);
    end
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) bq[i].delete();
    exp_d.delete(); exp_v.delete(); obs_d.delete(); obs_v.delete();
    mptr = 0;
    bus.vc_data = '0;
  endtask

  task automatic set_empty();
    for (int i = 0; i < 4; i++) bus.vc_empty[i] = (bq[i].size() == 0);
  endtask

  // Buffers are queues; every granted flit is owed to the output in grant order.
  task automatic model_cycle();
    logic [3:0] srd;
    bit         pop;
    int         occ;
    int         v;
`ifndef VC_PKT_LOCK_EN
    int         g;
    logic [3:0] erd;
`endif
    v = 0;
    @(negedge clk);
    srd = bus.rd_en;
    pop = bus.out_valid && bus.out_ready;
    occ = exp_d.size();
`ifndef VC_PKT_LOCK_EN
    g = -1;
    for (int k = 1; k <= 4; k++)
      if (g < 0 && !bus.vc_empty[(mptr + k) % 4]) g = (mptr + k) % 4;
    erd = 4'b0000;
    if (g >= 0 && (occ - int'(pop)) < 2) erd[g] = 1'b1;
    chk("rand_rd_en", srd, erd);
`endif
    chk("rand_rd_onehot", ($countones(srd) <= 1), 1);
    if (pop) begin
      if (exp_d.size() == 0) begin
        chk("rand_out_valid_unexpected", bus.out_valid, 0);
      end else begin
        chk("rand_out_data", bus.out_data, exp_d[0]);
        chk("rand_out_vc", bus.out_vc, exp_v[0]);
        obs_d.push_back(bus.out_data);
        obs_v.push_back(bus.out_vc);
        void'(exp_d.pop_front());
        void'(exp_v.pop_front());
      end
    end
    if (srd != 4'b0000) begin
      v = int'(enc(srd));
      chk("rand_rd_nonempty", bus.vc_empty[v], 0);
      chk("rand_rr_select", bus.rr_select, v);
      if (bq[v].size() > 0) begin
        exp_d.push_back(bq[v][0]);
        exp_v.push_back(2'(v));
      end
      mptr = v;
    end
    @(posedge clk); #1;
    if (srd != 4'b0000 && bq[v].size() > 0) bus.vc_data[v*8 +: 8] = bq[v].pop_front();
    set_empty();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.vc_empty  = 4'b0000;
    bus.out_ready = 1'b0;
    const_data();

`ifndef VC_PKT_LOCK_EN
    // all VCs full, out_ready=1: S,E,W,N,S stream
    vecs.push_back(mk(1, 4'b0000, 1, 4'b0010, 0, 8'h00, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0100, 0, 8'h00, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b1000, 1, 8'h22, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0001, 1, 8'h33, 2'd2));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0010, 1, 8'h44, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0100, 1, 8'h11, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b1000, 1, 8'h22, 2'd1));
    // backpressure: two reads only, head frozen, then resume in order
    vecs.push_back(mk(1, 4'b0000, 0, 4'b0010, 0, 8'h00, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0100, 0, 8'h00, 2'd0));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 8'h22, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 8'h22, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 1, 8'h22, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b1000, 1, 8'h22, 2'd1));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0001, 1, 8'h33, 2'd2));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0010, 1, 8'h44, 2'd3));
    vecs.push_back(mk(0, 4'b0000, 1, 4'b0100, 1, 8'h11, 2'd0));
    // only E, toggling empty every cycle
    vecs.push_back(mk(1, 4'b1011, 1, 4'b0100, 0, 8'h00, 2'd0));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 8'h00, 2'd0));
    vecs.push_back(mk(0, 4'b1011, 1, 4'b0100, 1, 8'h33, 2'd2));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 8'h00, 2'd0));
    vecs.push_back(mk(0, 4'b1011, 1, 4'b0100, 1, 8'h33, 2'd2));
    vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 8'h00, 2'd0));
    foreach (vecs[i]) run_vec(vecs[i]);
`endif

    // async reset while a flit is queued and a read is in flight
    do_reset();
    bus.vc_empty  = 4'b0000;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("async_pre_out_valid", bus.out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_rd_en", bus.rd_en, 0);
    bus.vc_empty = 4'b1111;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_out_valid", bus.out_valid, 0);
      chk("post_rst_rd_en", bus.rd_en, 0);
    end
    @(posedge clk); #1;

`ifdef VC_PKT_LOCK_EN
    // W packet 05,06,87 must go out contiguously ahead of N
    do_reset();
    model_reset();
    bq[3].push_back(8'h05); bq[3].push_back(8'h06); bq[3].push_back(8'h87);
    for (int k = 0; k < 10; k++) bq[0].push_back(8'(8'h81 + k));
    bus.out_ready = 1'b1;
    set_empty();
    repeat (16) model_cycle();
    chk("lock_obs_count", (obs_d.size() >= 4), 1);
    if (obs_d.size() >= 4) begin
      chk("lock_w0_data", obs_d[0], 8'h05);
      chk("lock_w1_data", obs_d[1], 8'h06);
      chk("lock_w2_data", obs_d[2], 8'h87);
      chk("lock_w0_vc", obs_v[0], 2'd3);
      chk("lock_w1_vc", obs_v[1], 2'd3);
      chk("lock_w2_vc", obs_v[2], 2'd3);
      chk("lock_next_vc", obs_v[3], 2'd0);
    end
`endif

    // random traffic against the queue model
    do_reset();
    model_reset();
    set_empty();
    for (int c = 0; c < 1500; c++) begin
      bus.out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++)
        if (bq[i].size() < 4 && $urandom_range(0, 2) == 0) bq[i].push_back(8'($urandom));
      set_empty();
      model_cycle();
    end
    bus.out_ready = 1'b1;
    repeat (24) model_cycle();
    chk("drain_owed_flits", exp_d.size(), 0);
    chk("drain_out_valid", bus.out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
